// File: rtl/irq_controller_n_if.sv
// Bus bundle between the interrupt controller and the CPU core/peripherals:
// interrupt lines, CPU handshake and the configuration register port.
interface irq_controller_n_if #(
    parameter int NUM_IRQ  = 16,
    parameter int ID_WIDTH = 8
);
    logic [NUM_IRQ-1:0]  irq;
    logic                int_disabled;
    logic                int_ack;
    logic                cfg_we;
    logic [1:0]          cfg_addr;
    logic [NUM_IRQ-1:0]  cfg_wdata;
    logic [NUM_IRQ-1:0]  cfg_rdata;
    logic                int_cpu;
    logic [ID_WIDTH-1:0] int_id;

    modport slave (
        input  irq, int_disabled, int_ack, cfg_we, cfg_addr, cfg_wdata,
        output cfg_rdata, int_cpu, int_id
    );

    modport master (
        output irq, int_disabled, int_ack, cfg_we, cfg_addr, cfg_wdata,
        input  cfg_rdata, int_cpu, int_id
    );
endinterface

// File: rtl/irq_controller_n.sv
// Parametrised interrupt controller: per-channel mask, edge/level mode,
// W1C pending bits, software trigger and fixed lowest-index priority with
// an explicit CPU acknowledge handshake.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no request outstanding; dispatch lowest eligible pending bit
// REQ   | int_cpu high, int_id stable, waiting for int_ack
module irq_controller_n #(
    parameter int                 NUM_IRQ    = 16,
    parameter int                 ID_WIDTH   = 8,
    parameter logic [NUM_IRQ-1:0] RESET_MASK = {NUM_IRQ{1'b1}},
    parameter logic [NUM_IRQ-1:0] RESET_MODE = {NUM_IRQ{1'b1}}
) (
    input logic               clk,
    input logic               reset,
    irq_controller_n_if.slave bus
);

    typedef enum logic {IDLE, REQ} state_t;

    state_t               state, state_nxt;
    logic [NUM_IRQ-1:0]   irq_prev;
    logic [NUM_IRQ-1:0]   pending;
    logic [NUM_IRQ-1:0]   mask;
    logic [NUM_IRQ-1:0]   mode;
    logic [ID_WIDTH-1:0]  int_id_q;

    logic [NUM_IRQ-1:0]   eligible;
    logic [NUM_IRQ-1:0]   grant_vec;
    logic [ID_WIDTH-1:0]  grant_id;
    logic                 grant_found;
    logic                 dispatch;
    logic [NUM_IRQ-1:0]   set_vec;
    logic [NUM_IRQ-1:0]   clr_vec;
    logic                 wr_mask, wr_mode, wr_w1c, wr_swi;

    assign wr_mask = bus.cfg_we && (bus.cfg_addr == 2'd0);
    assign wr_mode = bus.cfg_we && (bus.cfg_addr == 2'd1);
    assign wr_w1c  = bus.cfg_we && (bus.cfg_addr == 2'd2);
    assign wr_swi  = bus.cfg_we && (bus.cfg_addr == 2'd3);

    assign eligible = pending & mask;

    // Set sources OR'd after the clear so a coincident event always survives.
    assign set_vec = (mode & bus.irq & ~irq_prev)
                   | (~mode & bus.irq)
                   | (wr_swi ? bus.cfg_wdata : '0);
    assign clr_vec = (dispatch ? grant_vec : '0)
                   | (wr_w1c ? bus.cfg_wdata : '0);

    // Lowest-index eligible channel wins.
    always_comb begin
        grant_vec   = '0;
        grant_id    = '0;
        grant_found = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (eligible[i] && !grant_found) begin
                grant_found  = 1'b1;
                grant_vec[i] = 1'b1;
                grant_id     = ID_WIDTH'(i + 1);
            end
        end
    end

    // Next-state logic; dispatch only from IDLE so REQ ignores int_disabled.
    always_comb begin
        state_nxt = state;
        dispatch  = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.int_disabled && grant_found) begin
                    dispatch  = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (bus.int_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Edge history, pending/config registers and the latched channel id.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_prev <= '0;
            pending  <= '0;
            mask     <= RESET_MASK;
            mode     <= RESET_MODE;
            int_id_q <= '0;
        end else begin
            irq_prev <= bus.irq;
            pending  <= (pending & ~clr_vec) | set_vec;
            if (wr_mask) begin
                mask <= bus.cfg_wdata;
            end
            if (wr_mode) begin
                mode <= bus.cfg_wdata;
            end
            if (dispatch) begin
                int_id_q <= grant_id;
            end
        end
    end

    // Zero-latency register readback; the trigger address has no storage.
    always_comb begin
        bus.cfg_rdata = '0;
        case (bus.cfg_addr)
            2'd0:    bus.cfg_rdata = mask;
            2'd1:    bus.cfg_rdata = mode;
            2'd2:    bus.cfg_rdata = pending;
            default: bus.cfg_rdata = '0;
        endcase
    end

    assign bus.int_cpu = (state == REQ);
    assign bus.int_id  = int_id_q;

endmodule

// File: tb/tb_irq_controller_n.sv
// Directed bench for irq_controller_n: inputs change 1 ns after the rising
// edge, outputs are sampled there too (register reads 1 ns later still).
module tb_irq_controller_n;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    irq_controller_n_if #(.NUM_IRQ(16), .ID_WIDTH(8)) bus ();

    irq_controller_n #(.NUM_IRQ(16), .ID_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.irq = '0; bus.int_disabled = 1'b0; bus.int_ack = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_addr = 2'd0; bus.cfg_wdata = '0;
        tick(); tick();
        reset = 1'b0;
        n_cmp++; if (bus.int_cpu !== 1'b0) begin n_err++; $display("FAIL reset_int_cpu: got %0b want 0", bus.int_cpu); end
        n_cmp++; if (bus.int_id !== 8'd0) begin n_err++; $display("FAIL reset_int_id: got %0d want 0", bus.int_id); end
        bus.cfg_addr = 2'd0; #1;
        n_cmp++; if (bus.cfg_rdata !== 16'hFFFF) begin n_err++; $display("FAIL reset_mask: got %h want ffff", bus.cfg_rdata); end
        bus.cfg_addr = 2'd1; #1;
        n_cmp++; if (bus.cfg_rdata !== 16'hFFFF) begin n_err++; $display("FAIL reset_mode: got %h want ffff", bus.cfg_rdata); end
        bus.cfg_addr = 2'd2; #1;
        n_cmp++; if (bus.cfg_rdata !== 16'h0000) begin n_err++; $display("FAIL reset_pending: got %h want 0000", bus.cfg_rdata); end
    endtask

    task automatic test_single_edge();
        bus.irq = 16'h0001;
        tick();                     // E0: pending[0] set
        bus.irq = '0;
        n_cmp++; if (bus.int_cpu !== 1'b0) begin n_err++; $display("FAIL single_e0_cpu: got %0b want 0", bus.int_cpu); end
        tick();                     // E1: dispatched
        n_cmp++; if (bus.int_cpu !== 1'b1) begin n_err++; $display("FAIL single_e1_cpu: got %0b want 1", bus.int_cpu); end
        n_cmp++; if (bus.int_id !== 8'd1) begin n_err++; $display("FAIL single_e1_id: got %0d want 1", bus.int_id); end
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++; if (bus.int_cpu !== 1'b1 || bus.int_id !== 8'd1) begin n_err++; $display("FAIL single_hold: cyc %0d got cpu=%0b id=%0d want cpu=1 id=1", c, bus.int_cpu, bus.int_id); end
        end
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        n_cmp++; if (bus.int_cpu !== 1'b0) begin n_err++; $display("FAIL single_ack_cpu: got %0b want 0", bus.int_cpu); end
        n_cmp++; if (bus.int_id !== 8'd1) begin n_err++; $display("FAIL single_id_kept: got %0d want 1", bus.int_id); end
        bus.cfg_addr = 2'd2; #1;
        n_cmp++; if (bus.cfg_rdata !== 16'h0000) begin n_err++; $display("FAIL single_pending: got %h want 0000", bus.cfg_rdata); end
    endtask

    task automatic test_priority();
        bus.irq = 16'h0024;
        tick();
        bus.irq = '0;
        tick();
        n_cmp++; if (bus.int_cpu !== 1'b1 || bus.int_id !== 8'd3) begin n_err++; $display("FAIL prio_first: got cpu=%0b id=%0d want cpu=1 id=3", bus.int_cpu, bus.int_id); end
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        n_cmp++; if (bus.int_cpu !== 1'b0) begin n_err++; $display("FAIL prio_gap: got %0b want 0", bus.int_cpu); end
        tick();
        n_cmp++; if (bus.int_cpu !== 1'b1 || bus.int_id !== 8'd6) begin n_err++; $display("FAIL prio_second: got cpu=%0b id=%0d want cpu=1 id=6", bus.int_cpu, bus.int_id); end
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (bus.int_cpu !== 1'b0) begin n_err++; $display("FAIL prio_quiet: cyc %0d got %0b want 0", c, bus.int_cpu); end
        end
    endtask

    task automatic test_mask();
        bus.cfg_we = 1'b1; bus.cfg_addr = 2'd0; bus.cfg_wdata = 16'hFFEF;
        tick();
        bus.cfg_we = 1'b0;
        bus.irq = 16'h0010;
        tick();
        bus.irq = '0;
        tick(); tick();
        n_cmp++; if (bus.int_cpu !== 1'b0) begin n_err++; $display("FAIL mask_blocked: got %0b want 0", bus.int_cpu); end
        bus.cfg_addr = 2'd2; #1;
        n_cmp++; if (bus.cfg_rdata !== 16'h0010) begin n_err++; $display("FAIL mask_pending: got %h want 0010", bus.cfg_rdata); end
        bus.cfg_we = 1'b1; bus.cfg_addr = 2'd0; bus.cfg_wdata = 16'hFFFF;
        tick();
        bus.cfg_we = 1'b0;
        n_cmp++; if (bus.int_cpu !== 1'b0) begin n_err++; $display("FAIL mask_write_edge: got %0b want 0", bus.int_cpu); end
        tick();
        n_cmp++; if (bus.int_cpu !== 1'b1 || bus.int_id !== 8'd5) begin n_err++; $display("FAIL mask_release: got cpu=%0b id=%0d want cpu=1 id=5", bus.int_cpu, bus.int_id); end
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        tick();
    endtask

    task automatic test_level();
        bus.cfg_we = 1'b1; bus.cfg_addr = 2'd1; bus.cfg_wdata = 16'hFFFD;
        tick();
        bus.cfg_we = 1'b0;
        bus.irq = 16'h0002;
        tick(); tick();
        n_cmp++; if (bus.int_cpu !== 1'b1 || bus.int_id !== 8'd2) begin n_err++; $display("FAIL level_first: got cpu=%0b id=%0d want cpu=1 id=2", bus.int_cpu, bus.int_id); end
        tick();
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        bus.irq = '0;               // line drops before the second ack
        n_cmp++; if (bus.int_cpu !== 1'b0) begin n_err++; $display("FAIL level_ack1: got %0b want 0", bus.int_cpu); end
        tick();
        n_cmp++; if (bus.int_cpu !== 1'b1 || bus.int_id !== 8'd2) begin n_err++; $display("FAIL level_redispatch: got cpu=%0b id=%0d want cpu=1 id=2", bus.int_cpu, bus.int_id); end
        tick();
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (bus.int_cpu !== 1'b0) begin n_err++; $display("FAIL level_no_third: cyc %0d got %0b want 0", c, bus.int_cpu); end
        end
        bus.cfg_we = 1'b1; bus.cfg_addr = 2'd1; bus.cfg_wdata = 16'hFFFF;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic test_disabled();
        bus.int_disabled = 1'b1;
        bus.irq = 16'h0008;
        tick();
        bus.irq = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (bus.int_cpu !== 1'b0) begin n_err++; $display("FAIL dis_blocked: cyc %0d got %0b want 0", c, bus.int_cpu); end
        end
        bus.int_disabled = 1'b0;
        tick();
        n_cmp++; if (bus.int_cpu !== 1'b1 || bus.int_id !== 8'd4) begin n_err++; $display("FAIL dis_release: got cpu=%0b id=%0d want cpu=1 id=4", bus.int_cpu, bus.int_id); end
        bus.int_disabled = 1'b1;
        tick(); tick();
        n_cmp++; if (bus.int_cpu !== 1'b1 || bus.int_id !== 8'd4) begin n_err++; $display("FAIL dis_in_req: got cpu=%0b id=%0d want cpu=1 id=4", bus.int_cpu, bus.int_id); end
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        n_cmp++; if (bus.int_cpu !== 1'b0) begin n_err++; $display("FAIL dis_ack: got %0b want 0", bus.int_cpu); end
    endtask

    task automatic test_pending_ops();
        // int_disabled still high: pending bits accumulate without dispatch
        bus.cfg_we = 1'b1; bus.cfg_addr = 2'd2; bus.cfg_wdata = 16'h0080;
        bus.irq = 16'h0080;
        tick();
        bus.cfg_we = 1'b0; bus.irq = '0;
        bus.cfg_addr = 2'd2; #1;
        n_cmp++; if (bus.cfg_rdata !== 16'h0080) begin n_err++; $display("FAIL w1c_collision: got %h want 0080", bus.cfg_rdata); end
        bus.cfg_we = 1'b1; bus.cfg_addr = 2'd2; bus.cfg_wdata = 16'h0080;
        tick();
        bus.cfg_we = 1'b0;
        bus.cfg_addr = 2'd2; #1;
        n_cmp++; if (bus.cfg_rdata !== 16'h0000) begin n_err++; $display("FAIL w1c_clear: got %h want 0000", bus.cfg_rdata); end
        bus.irq = 16'h0080;
        tick();
        bus.irq = '0;
        bus.cfg_we = 1'b1; bus.cfg_addr = 2'd3; bus.cfg_wdata = 16'h0200;
        tick();
        bus.cfg_we = 1'b0;
        bus.cfg_addr = 2'd2; #1;
        n_cmp++; if (bus.cfg_rdata !== 16'h0280) begin n_err++; $display("FAIL swi_pending: got %h want 0280", bus.cfg_rdata); end
        bus.cfg_addr = 2'd3; #1;
        n_cmp++; if (bus.cfg_rdata !== 16'h0000) begin n_err++; $display("FAIL swi_readback: got %h want 0000", bus.cfg_rdata); end
        bus.int_disabled = 1'b0;
        tick();
        n_cmp++; if (bus.int_cpu !== 1'b1 || bus.int_id !== 8'd8) begin n_err++; $display("FAIL pend_dispatch: got cpu=%0b id=%0d want cpu=1 id=8", bus.int_cpu, bus.int_id); end
    endtask

    task automatic test_reset_in_req();
        bus.cfg_we = 1'b1; bus.cfg_addr = 2'd0; bus.cfg_wdata = 16'h0000;
        tick();
        bus.cfg_we = 1'b0;
        bus.cfg_addr = 2'd0; #1;
        n_cmp++; if (bus.cfg_rdata !== 16'h0000) begin n_err++; $display("FAIL rst_mask_written: got %h want 0000", bus.cfg_rdata); end
        reset = 1'b1;
        bus.irq = 16'h0001;
        tick();
        n_cmp++; if (bus.int_cpu !== 1'b0 || bus.int_id !== 8'd0) begin n_err++; $display("FAIL rst_req_out: got cpu=%0b id=%0d want cpu=0 id=0", bus.int_cpu, bus.int_id); end
        bus.cfg_addr = 2'd2; #1;
        n_cmp++; if (bus.cfg_rdata !== 16'h0000) begin n_err++; $display("FAIL rst_req_pending: got %h want 0000", bus.cfg_rdata); end
        bus.cfg_addr = 2'd0; #1;
        n_cmp++; if (bus.cfg_rdata !== 16'hFFFF) begin n_err++; $display("FAIL rst_req_mask: got %h want ffff", bus.cfg_rdata); end
        bus.irq = '0;
        tick();
        reset = 1'b0;
        tick(); tick();
        n_cmp++; if (bus.int_cpu !== 1'b0) begin n_err++; $display("FAIL rst_edge_dropped: got %0b want 0", bus.int_cpu); end
        // level held across reset release counts as a fresh edge
        reset = 1'b1;
        bus.irq = 16'h0004;
        tick();
        reset = 1'b0;
        tick(); tick();
        n_cmp++; if (bus.int_cpu !== 1'b1 || bus.int_id !== 8'd3) begin n_err++; $display("FAIL rst_held_level: got cpu=%0b id=%0d want cpu=1 id=3", bus.int_cpu, bus.int_id); end
        bus.irq = '0;
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        n_cmp++; if (bus.int_cpu !== 1'b0) begin n_err++; $display("FAIL rst_final_ack: got %0b want 0", bus.int_cpu); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_edge();
        test_priority();
        test_mask();
        test_level();
        test_disabled();
        test_pending_ops();
        test_reset_in_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/irq_controller_n.md
# irq_controller_n

Parametrised interrupt controller between the peripheral interrupt lines and the CPU core. Generalises the fixed 10-line controller to NUM_IRQ channels with per-channel enable mask, edge/level trigger mode, readable/clearable pending bits, software-triggered interrupts and an explicit CPU acknowledge handshake. The CPU saves the PC, jumps to the interrupt vector, reads the channel number from int_id, and pulses int_ack once the request is taken.

## Interface
- NUM_IRQ, 16, number of interrupt channels; legal range 1..32.
- ID_WIDTH, 8, width of int_id; must satisfy 2^ID_WIDTH > NUM_IRQ.
- RESET_MASK, {NUM_IRQ{1'b1}}, enable mask value after reset.
- RESET_MODE, {NUM_IRQ{1'b1}}, trigger mode after reset; bit=1 edge, bit=0 level.

- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- irq  in  NUM_IRQ  interrupt lines, synchronous to clk, active-high.
- int_disabled  in  1  CPU is in an ISR or has interrupts off; blocks new dispatch.
- int_ack  in  1  one-cycle pulse from CPU: the current request has been taken.
- cfg_we  in  1  configuration write strobe.
- cfg_addr  in  2  register select: 0 mask, 1 mode, 2 pending, 3 software trigger.
- cfg_wdata  in  NUM_IRQ  write data.
- cfg_rdata  out  NUM_IRQ  combinational read of the register selected by cfg_addr; address 3 reads 0.
- int_cpu  out  1  interrupt request to CPU.
- int_id  out  ID_WIDTH  channel number of the request; channel i (0-based) reports i+1; 0 = none since reset.

## Operation
- Registers: irq_prev, pending, mask, mode (each NUM_IRQ bits); state in {IDLE, REQ}.
- Reset: irq_prev=0, pending=0, mask=RESET_MASK, mode=RESET_MODE, int_cpu=0, int_id=0, state=IDLE.
- Every cycle, irq_prev<=irq.
- Set sources per bit i: edge mode (irq[i] & ~irq_prev[i]); level mode (irq[i]); software trigger (cfg_we, addr 3, cfg_wdata[i]=1).
- Clear sources per bit i: dispatch of channel i; write-1-to-clear (cfg_we, addr 2, cfg_wdata[i]=1).
- Set and clear of the same bit in the same cycle: set wins. An event coinciding with its own dispatch is never lost and re-dispatches later.
- Pending bits latch regardless of mask. Only pending & mask is eligible for dispatch.
- Mask/mode writes (addr 0/1) take effect from the next cycle.
- IDLE: if !int_disabled and (pending & mask) != 0, select the lowest eligible index k. Then pending[k]<=0, int_id<=k+1, int_cpu<=1, state<=REQ.
- REQ: int_cpu held at 1 and int_id held stable until int_ack. Then int_cpu<=0, state<=IDLE. int_disabled does not withdraw a request already in REQ.
- int_ack in IDLE is ignored. int_id keeps its last value after ack.
- Level-mode line still high after dispatch re-sets pending the next cycle, so it re-dispatches after ack. Once the line is low, nothing further is dispatched.

## Timing
- Edge at irq[i] first sampled high at edge E0: pending[i]=1 after E0. int_cpu=1 after E1 if IDLE, unmasked, not disabled, highest priority.
- Ack sampled at edge A: int_cpu=0 after A. Earliest next int_cpu=1 after A+1, giving at least one low cycle between requests.
- cfg_rdata: zero-latency combinational read. Pending readback reflects register state before the current edge.
- Reset asserted in any state: all outputs at reset values after that edge. Pending events are discarded and edges present during reset are not captured.
- A pulse one cycle wide is captured in edge mode. A level held high across reset release counts as an edge on the first non-reset cycle.

## Test plan
- After reset, pulse irq[0] one cycle at E0 -> int_cpu=1, int_id=1 after E1; held 5 cycles until int_ack pulse; int_cpu=0 next edge; cfg_rdata(addr 2)=0.
- Rising edges on irq[5] and irq[2] in the same cycle -> int_id=3 first; ack -> one idle cycle -> int_id=6; ack -> int_cpu stays 0.
- Write mask=~(1<<4), edge on irq[4] -> int_cpu stays 0, pending readback bit 4=1; write mask all ones -> int_id=5 two cycles later.
- Mode bit 1=0 (level), hold irq[1] high -> int_id=2 re-dispatched after each ack; drop irq[1] before the second ack -> no third request.
- int_disabled=1 with irq[3] edge -> no request while high; deassert -> int_id=4 next cycle; raise int_disabled during REQ -> int_cpu stays 1 until ack.
- W1C of bit 7 in the same cycle as an irq[7] edge -> pending bit 7 reads 1. Reset during REQ -> int_cpu=0, int_id=0, pending=0 after that edge.
